// File: rtl/sgdmac_pkg.sv
// ---------------------------------------------------------------------------
// sgdmac_pkg
// Definitions shared by the scatter-gather DMA write and read engines:
// engine state encoding, AXI burst geometry, and the AXI field constants
// driven on the address and data channels.
// ---------------------------------------------------------------------------
package sgdmac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_REQ  = 2'd1,
    DATA_TX   = 2'd2,
    RESP_WAIT = 2'd3
  } sgdmac_state_e;

  // One full burst is 16 beats of 4 bytes.
  localparam int          BURST_BYTES    = 64;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0]  AXI_STRB_ALL   = 4'hF;
  localparam logic [3:0]  AXI_ID_DEFAULT = 4'h0;

  // AXI length field for the next burst: a full 16-beat burst while at least
  // 64 bytes remain, otherwise the word count of the tail minus one. With
  // remain == 0 the subtraction wraps to 4'hF, which is the idle/reset value.
  function automatic logic [3:0] burst_awlen(input logic [15:0] remain);
    if (remain >= 16'(BURST_BYTES))
      return 4'hF;
    else
      return remain[5:2] - 4'd1;
  endfunction

endpackage

// File: rtl/sgdmac_write.sv
// ---------------------------------------------------------------------------
// sgdmac_write
// AXI3 write engine of the scatter-gather DMA. Takes one command
// {dst_addr, byte_count}, drains 32-bit words from an external
// first-word-fall-through buffer and writes them out as INCR bursts of up to
// 16 beats, with exactly one burst outstanding at a time.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start_i, cmd_i[47:0]    command strobe and {dst_addr[47:16], byte_count[15:0]}
//   done_o                  engine idle
//   err_o                   sticky: some write response was not OKAY
//   fifo_empty_i, fifo_cnt_i, fifo_rdata_i, fifo_rden_o
//                           FWFT data buffer (head word on fifo_rdata_i)
//   aw*                     AXI write-address channel
//   w*                      AXI write-data channel
//   b*                      AXI write-response channel
// ---------------------------------------------------------------------------
module sgdmac_write
  import sgdmac_pkg::*;
#(
  parameter  int FIFO_DEPTH = 64,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          start_i,
  input  logic [47:0]   cmd_i,
  output logic          done_o,
  output logic          err_o,

  input  logic          fifo_empty_i,
  input  logic [CW-1:0] fifo_cnt_i,
  input  logic [31:0]   fifo_rdata_i,
  output logic          fifo_rden_o,

  output logic [3:0]    awid_o,
  output logic [31:0]   awaddr_o,
  output logic [3:0]    awlen_o,
  output logic [2:0]    awsize_o,
  output logic [1:0]    awburst_o,
  output logic          awvalid_o,
  input  logic          awready_i,

  output logic [3:0]    wid_o,
  output logic [31:0]   wdata_o,
  output logic [3:0]    wstrb_o,
  output logic          wlast_o,
  output logic          wvalid_o,
  input  logic          wready_i,

  input  logic [3:0]    bid_i,
  input  logic [1:0]    bresp_i,
  input  logic          bvalid_i,
  output logic          bready_o
);

  sgdmac_state_e state, state_nxt;

  logic [31:0] awaddr_q;
  logic [15:0] remain_q;
  logic [3:0]  beat_cnt;
  logic [3:0]  burst_len;
  logic        err_q;
  logic        aw_pend;

  logic        start_go;
  logic [3:0]  awlen_c;
  logic        fifo_has_burst;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  // The single-ID engine never looks at the returned ID.
  logic        unused_bid;
  assign unused_bid = ^bid_i;

  assign start_go = start_i && (cmd_i[15:0] != 16'd0);

  // AW is only raised once the whole burst is already buffered, so the W
  // channel never stalls on an empty buffer for lack of data.
  assign awlen_c        = burst_awlen(remain_q);
  assign fifo_has_burst = (32'(fifo_cnt_i) >= (32'(awlen_c) + 32'd1));

  // aw_pend keeps AWVALID up once raised, even if the buffer level were to
  // drop, so the request is never withdrawn before AWREADY.
  assign awvalid_o = (state == ADDR_REQ) && (aw_pend || fifo_has_burst);
  assign aw_hs     = awvalid_o && awready_i;

  assign wvalid_o    = (state == DATA_TX) && !fifo_empty_i;
  assign w_hs        = wvalid_o && wready_i;
  assign wlast_o     = (state == DATA_TX) && (beat_cnt == burst_len);
  assign fifo_rden_o = w_hs;
  assign wdata_o     = fifo_rdata_i;

  assign bready_o = (state == RESP_WAIT);
  assign b_hs     = bvalid_i && bready_o;

  assign done_o    = (state == IDLE);
  assign err_o     = err_q;
  assign awaddr_o  = awaddr_q;
  assign awlen_o   = awlen_c;
  assign awid_o    = AXI_ID_DEFAULT;
  assign awsize_o  = AXI_SIZE_4B;
  assign awburst_o = AXI_BURST_INCR;
  assign wid_o     = AXI_ID_DEFAULT;
  assign wstrb_o   = AXI_STRB_ALL;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start_go)        state_nxt = ADDR_REQ;
      ADDR_REQ:  if (aw_hs)           state_nxt = DATA_TX;
      DATA_TX:   if (w_hs && wlast_o) state_nxt = RESP_WAIT;
      RESP_WAIT: if (b_hs)            state_nxt = (remain_q == 16'd0) ? IDLE : ADDR_REQ;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Burst bookkeeping. Reset clears everything so an interrupted transfer
  // leaves no residue for the next command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q  <= 32'd0;
      remain_q  <= 16'd0;
      beat_cnt  <= 4'd0;
      burst_len <= 4'd0;
      err_q     <= 1'b0;
      aw_pend   <= 1'b0;
    end else begin
      aw_pend <= awvalid_o && !awready_i;

      unique case (state)
        IDLE: begin
          if (start_go) begin
            awaddr_q <= cmd_i[47:16];
            remain_q <= cmd_i[15:0];
            err_q    <= 1'b0;
          end
        end
        ADDR_REQ: begin
          if (aw_hs) begin
            burst_len <= awlen_c;
            awaddr_q  <= awaddr_q + 32'(BURST_BYTES);
            remain_q  <= (remain_q >= 16'(BURST_BYTES)) ?
                         (remain_q - 16'(BURST_BYTES)) : 16'd0;
            beat_cnt  <= 4'd0;
          end
        end
        DATA_TX: begin
          if (w_hs)
            beat_cnt <= beat_cnt + 4'd1;
        end
        RESP_WAIT: begin
          if (b_hs && (bresp_i != AXI_RESP_OKAY))
            err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sgdmac_write.sv
module tb_sgdmac_write;

  localparam int FIFO_DEPTH = 64;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [47:0]   cmd_i;
  logic          done_o;
  logic          err_o;
  logic          fifo_empty_i;
  logic [CW-1:0] fifo_cnt_i;
  logic [31:0]   fifo_rdata_i;
  logic          fifo_rden_o;
  logic [3:0]    awid_o;
  logic [31:0]   awaddr_o;
  logic [3:0]    awlen_o;
  logic [2:0]    awsize_o;
  logic [1:0]    awburst_o;
  logic          awvalid_o;
  logic          awready_i;
  logic [3:0]    wid_o;
  logic [31:0]   wdata_o;
  logic [3:0]    wstrb_o;
  logic          wlast_o;
  logic          wvalid_o;
  logic          wready_i;
  logic [3:0]    bid_i;
  logic [1:0]    bresp_i;
  logic          bvalid_i;
  logic          bready_o;

  sgdmac_write #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .cmd_i(cmd_i), .done_o(done_o), .err_o(err_o),
    .fifo_empty_i(fifo_empty_i), .fifo_cnt_i(fifo_cnt_i),
    .fifo_rdata_i(fifo_rdata_i), .fifo_rden_o(fifo_rden_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // FWFT buffer model and channel monitor state
  logic [31:0] fq[$];
  logic        empty_force;
  logic        rand_wready;
  int          err_on_b;
  int          pulse_lo, pulse_hi;
  int          cyc;

  logic [31:0] aw_addr_log[$];
  logic [3:0]  aw_len_log[$];
  logic [31:0] w_data_log[$];
  int          wlast_beat_log[$];
  int          rden_cnt, b_cnt, rden_bad, wlast_bad, hold_bad, beat_in_burst;
  logic [3:0]  cur_len;
  logic        awv_prev;
  logic [31:0] awaddr_prev;
  logic [3:0]  awlen_prev;
  logic        s_awvalid, s_done, s_err;

  task automatic fifo_refresh();
    fifo_empty_i = empty_force || (fq.size() == 0);
    fifo_cnt_i   = CW'(fq.size());
    fifo_rdata_i = (fq.size() > 0) ? fq[0] : 32'h0;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 32'(i));
    fifo_refresh();
  endtask

  task automatic clear_logs();
    aw_addr_log.delete(); aw_len_log.delete();
    w_data_log.delete(); wlast_beat_log.delete();
    rden_cnt = 0; b_cnt = 0; rden_bad = 0; wlast_bad = 0; hold_bad = 0;
    beat_in_burst = 0; cur_len = 4'd0; awv_prev = 1'b0; cyc = 0;
    pulse_lo = 0; pulse_hi = 0; err_on_b = -1; rand_wready = 1'b0;
    empty_force = 1'b0;
  endtask

  // One clock: sample at the falling edge, then update the buffer model and
  // the driven inputs just after the rising edge.
  task automatic step();
    logic rd;
    logic whs;
    @(negedge clk);
    s_awvalid = awvalid_o; s_done = done_o; s_err = err_o;
    if (awv_prev && (!awvalid_o || awaddr_o != awaddr_prev || awlen_o != awlen_prev))
      hold_bad++;
    awv_prev = awvalid_o && !awready_i;
    awaddr_prev = awaddr_o; awlen_prev = awlen_o;
    if (wlast_o && beat_in_burst != int'(cur_len)) wlast_bad++;
    whs = wvalid_o && wready_i;
    rd = fifo_rden_o;
    if (rd && !whs) rden_bad++;
    if (rd) rden_cnt++;
    if (awvalid_o && awready_i) begin
      aw_addr_log.push_back(awaddr_o);
      aw_len_log.push_back(awlen_o);
      cur_len = awlen_o;
      beat_in_burst = 0;
    end
    if (whs) begin
      w_data_log.push_back(wdata_o);
      if (wlast_o) wlast_beat_log.push_back(beat_in_burst + 1);
      beat_in_burst++;
    end
    if (bvalid_i && bready_o) b_cnt++;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    cyc++;
    empty_force = (cyc >= pulse_lo) && (cyc < pulse_hi);
    wready_i = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
    bresp_i = (b_cnt == err_on_b) ? 2'b10 : 2'b00;
    fifo_refresh();
  endtask

  task automatic issue(input logic [47:0] cmd);
    start_i = 1'b1;
    cmd_i = cmd;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (s_done) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: done_o=0 after %0d cycles, required 1", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL rst_done: got %b want 1", done_o); end
    total++; if ({awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o} !== 5'b0) begin
      bad++; $display("FAIL rst_valids: got %b want 00000", {awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o}); end
    total++; if (awlen_o !== 4'hF) begin bad++; $display("FAIL rst_awlen: got %h want f", awlen_o); end
    total++; if (err_o !== 1'b0 || awaddr_o !== 32'h0) begin
      bad++; $display("FAIL rst_err_addr: got err=%b addr=%h want 0/0", err_o, awaddr_o); end
    total++; if ({awsize_o, awburst_o, wstrb_o, awid_o, wid_o} !== {3'b010, 2'b01, 4'hF, 4'h0, 4'h0}) begin
      bad++; $display("FAIL consts: got %h want %h", {awsize_o, awburst_o, wstrb_o, awid_o, wid_o},
                      {3'b010, 2'b01, 4'hF, 4'h0, 4'h0}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_count();
    clear_logs();
    issue({32'h7000_0000, 16'd0});
    step();
    total++; if (s_done !== 1'b1 || s_awvalid !== 1'b0 || aw_addr_log.size() != 0) begin
      bad++; $display("FAIL zero_count: got done=%b awvalid=%b aws=%0d want 1/0/0",
                      s_done, s_awvalid, aw_addr_log.size()); end
  endtask

  task automatic test_single_burst();
    int miss;
    clear_logs();
    push_words(32'hA000_0000, 16);
    issue({32'h1000_0000, 16'd64});
    run_until_done("single", 200);
    total++; if (aw_addr_log.size() != 1 || aw_addr_log[0] !== 32'h1000_0000 || aw_len_log[0] !== 4'hF) begin
      bad++; $display("FAIL single_aw: got n=%0d addr=%h len=%h want 1/10000000/f", aw_addr_log.size(),
                      (aw_addr_log.size() > 0) ? aw_addr_log[0] : 32'hx, (aw_len_log.size() > 0) ? aw_len_log[0] : 4'hx); end
    miss = 0;
    for (int i = 0; i < w_data_log.size(); i++) if (w_data_log[i] !== 32'hA000_0000 + 32'(i)) miss++;
    total++; if (w_data_log.size() != 16 || miss != 0) begin
      bad++; $display("FAIL single_wdata: got beats=%0d misordered=%0d want 16/0", w_data_log.size(), miss); end
    total++; if (wlast_beat_log.size() != 1 || wlast_beat_log[0] != 16 || wlast_bad != 0) begin
      bad++; $display("FAIL single_wlast: got n=%0d stray=%0d want one on beat 16", wlast_beat_log.size(), wlast_bad); end
    total++; if (b_cnt != 1 || rden_cnt != 16 || s_err !== 1'b0) begin
      bad++; $display("FAIL single_b_rden: got b=%0d rden=%0d err=%b want 1/16/0", b_cnt, rden_cnt, s_err); end
  endtask

  task automatic test_two_bursts();
    clear_logs();
    push_words(32'hB000_0000, 18);
    issue({32'h2000_0000, 16'd72});
    run_until_done("two", 300);
    total++; if (aw_addr_log.size() != 2) begin
      bad++; $display("FAIL two_aw_count: got %0d want 2", aw_addr_log.size()); end
    else begin
      total++; if (aw_addr_log[0] !== 32'h2000_0000 || aw_len_log[0] !== 4'hF ||
                   aw_addr_log[1] !== 32'h2000_0040 || aw_len_log[1] !== 4'h1) begin
        bad++; $display("FAIL two_aw: got %h/%h %h/%h want 20000000/f 20000040/1",
                        aw_addr_log[0], aw_len_log[0], aw_addr_log[1], aw_len_log[1]); end
    end
    total++; if (rden_cnt != 18 || w_data_log.size() != 18 || b_cnt != 2) begin
      bad++; $display("FAIL two_rden: got rden=%0d beats=%0d b=%0d want 18/18/2", rden_cnt, w_data_log.size(), b_cnt); end
    total++; if (wlast_beat_log.size() != 2 || wlast_beat_log[0] != 16 || wlast_beat_log[1] != 2) begin
      bad++; $display("FAIL two_wlast: got n=%0d want beats 16 and 2", wlast_beat_log.size()); end
  endtask

  task automatic test_fifo_threshold();
    clear_logs();
    push_words(32'hC000_0000, 3);
    issue({32'h3000_0000, 16'd64});
    repeat (3) step();
    total++; if (s_awvalid !== 1'b0 || awlen_o !== 4'hF) begin
      bad++; $display("FAIL thresh_low: got awvalid=%b awlen=%h want 0/f", s_awvalid, awlen_o); end
    push_words(32'hC000_0003, 13);
    step();
    total++; if (s_awvalid !== 1'b1) begin bad++; $display("FAIL thresh_high: got awvalid=%b want 1", s_awvalid); end
    run_until_done("thresh", 200);
    total++; if (w_data_log.size() != 16 || hold_bad != 0) begin
      bad++; $display("FAIL thresh_beats: got beats=%0d holdviol=%0d want 16/0", w_data_log.size(), hold_bad); end
  endtask

  task automatic test_wready_random();
    int miss;
    clear_logs();
    push_words(32'hD000_0000, 32);
    rand_wready = 1'b1;
    pulse_lo = 8; pulse_hi = 11;
    issue({32'h4000_0000, 16'd128});
    run_until_done("rand", 600);
    rand_wready = 1'b0;
    wready_i = 1'b1;
    miss = 0;
    for (int i = 0; i < w_data_log.size(); i++) if (w_data_log[i] !== 32'hD000_0000 + 32'(i)) miss++;
    total++; if (w_data_log.size() != 32 || miss != 0) begin
      bad++; $display("FAIL rand_order: got beats=%0d misordered=%0d want 32/0", w_data_log.size(), miss); end
    total++; if (rden_bad != 0 || rden_cnt != 32) begin
      bad++; $display("FAIL rand_rden: got stray=%0d total=%0d want 0/32", rden_bad, rden_cnt); end
    total++; if (wlast_bad != 0 || wlast_beat_log.size() != 2 || wlast_beat_log[0] != 16 || wlast_beat_log[1] != 16) begin
      bad++; $display("FAIL rand_wlast: got stray=%0d n=%0d want 0/2 on beat 16", wlast_bad, wlast_beat_log.size()); end
    total++; if (aw_addr_log.size() != 2 || aw_addr_log[1] !== 32'h4000_0040) begin
      bad++; $display("FAIL rand_aw: got n=%0d want 2, second at 40000040", aw_addr_log.size()); end
  endtask

  task automatic test_bresp_err();
    clear_logs();
    push_words(32'hE000_0000, 32);
    err_on_b = 0;
    bresp_i = 2'b10;
    issue({32'h5000_0000, 16'd128});
    run_until_done("err", 300);
    total++; if (s_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got err=%b want 1", s_err); end
    total++; if (aw_addr_log.size() != 2 || aw_addr_log[1] !== 32'h5000_0040 || b_cnt != 2) begin
      bad++; $display("FAIL err_second: got aw=%0d b=%0d want 2/2", aw_addr_log.size(), b_cnt); end
    clear_logs();
    bresp_i = 2'b00;
    push_words(32'hE100_0000, 1);
    issue({32'h5100_0000, 16'd4});
    step();
    total++; if (s_err !== 1'b0) begin bad++; $display("FAIL err_clear: got err=%b want 0", s_err); end
    run_until_done("err2", 100);
    total++; if (aw_len_log.size() != 1 || aw_len_log[0] !== 4'h0 || w_data_log.size() != 1 || s_err !== 1'b0) begin
      bad++; $display("FAIL err_single_word: got aw=%0d beats=%0d err=%b want 1 len0/1/0",
                      aw_len_log.size(), w_data_log.size(), s_err); end
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    int miss;
    clear_logs();
    push_words(32'hF000_0000, 16);
    issue({32'h6000_0000, 16'd64});
    guard = 0;
    while (w_data_log.size() < 4 && guard < 100) begin step(); guard++; end
    total++; if (w_data_log.size() != 4) begin
      bad++; $display("FAIL midrst_reach: got beats=%0d want 4", w_data_log.size()); end
    rst_n = 1'b0;
    #1;
    total++; if ({awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o} !== 5'b0 || done_o !== 1'b1) begin
      bad++; $display("FAIL midrst_outputs: got valids=%b done=%b want 00000/1",
                      {awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o}, done_o); end
    repeat (2) step();
    total++; if (w_data_log.size() != 4 || rden_cnt != 4) begin
      bad++; $display("FAIL midrst_quiet: got beats=%0d rden=%0d want 4/4", w_data_log.size(), rden_cnt); end
    rst_n = 1'b1;
    fq.delete();
    clear_logs();
    push_words(32'h1234_0000, 4);
    step();
    issue({32'h6100_0000, 16'd16});
    run_until_done("midrst_new", 100);
    miss = 0;
    for (int i = 0; i < w_data_log.size(); i++) if (w_data_log[i] !== 32'h1234_0000 + 32'(i)) miss++;
    total++; if (aw_addr_log.size() != 1 || aw_addr_log[0] !== 32'h6100_0000 || aw_len_log[0] !== 4'h3 ||
                 w_data_log.size() != 4 || miss != 0) begin
      bad++; $display("FAIL midrst_new: got aw=%0d beats=%0d misordered=%0d want 1 @61000000 len3/4/0",
                      aw_addr_log.size(), w_data_log.size(), miss); end
  endtask

  initial begin
    total = 0; bad = 0;
    start_i = 1'b0; cmd_i = 48'h0;
    awready_i = 1'b1; wready_i = 1'b1;
    bvalid_i = 1'b1; bid_i = 4'h0; bresp_i = 2'b00;
    rst_n = 1'b0;
    clear_logs();
    fifo_refresh();

    test_reset();
    test_zero_count();
    test_single_burst();
    test_two_bursts();
    test_fifo_threshold();
    test_wready_random();
    test_bresp_err();
    test_reset_mid_burst();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
